// File: rtl/macro_vector_driver.sv
// Host-driven stimulus/capture sequencer for a macro under test: takes a
// stimulus, expected and settle byte, waits, captures the response and reports.
module macro_vector_driver #(
  parameter int SETTLE_W = 8,
  parameter int VEC_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [VEC_W-1:0]   mac_in,
  input  logic [VEC_W-1:0]   mac_out,
  output logic [7:0]         rsp_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               mismatch,
  output logic [7:0]         err_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_EXP, S_GET_SET, S_SETTLE, S_CAPTURE, S_SEND
  } state_t;

  state_t r_state, w_next;

  logic [VEC_W-1:0]    r_stim, r_exp, r_mac_in;
  logic [SETTLE_W-1:0] r_settle;
  logic [7:0]          r_rsp, r_err;
  logic                r_mismatch;

  logic [VEC_W-1:0]    w_cmd_vec;
  logic [SETTLE_W-1:0] w_cmd_settle;
  logic [7:0]          w_out_byte;
  logic                w_xfer, w_mm;

  // Byte <-> vector conversion is LSB-aligned: zero-extend or truncate.
  if (VEC_W > 8) begin : g_vec_wide
    assign w_cmd_vec  = {{(VEC_W-8){1'b0}}, cmd_data};
    assign w_out_byte = mac_out[7:0];
  end else if (VEC_W == 8) begin : g_vec_byte
    assign w_cmd_vec  = cmd_data;
    assign w_out_byte = mac_out;
  end else begin : g_vec_narrow
    assign w_cmd_vec  = cmd_data[VEC_W-1:0];
    assign w_out_byte = {{(8-VEC_W){1'b0}}, mac_out};
  end

  if (SETTLE_W > 8) begin : g_set_wide
    assign w_cmd_settle = {{(SETTLE_W-8){1'b0}}, cmd_data};
  end else if (SETTLE_W == 8) begin : g_set_byte
    assign w_cmd_settle = cmd_data;
  end else begin : g_set_narrow
    assign w_cmd_settle = cmd_data[SETTLE_W-1:0];
  end

  assign w_xfer = cmd_valid && cmd_ready;
  assign w_mm   = (mac_out != r_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_xfer) w_next = S_GET_EXP;
      S_GET_EXP: if (w_xfer) w_next = S_GET_SET;
      S_GET_SET: if (w_xfer) w_next = S_SETTLE;
      S_SETTLE:  if (r_settle == '0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE:    begin cmd_ready = 1'b1; busy = 1'b0; end
      S_GET_EXP: cmd_ready = 1'b1;
      S_GET_SET: cmd_ready = 1'b1;
      S_SEND:    rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stim     <= '0;
      r_exp      <= '0;
      r_mac_in   <= '0;
      r_settle   <= '0;
      r_rsp      <= '0;
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_xfer)    r_stim <= w_cmd_vec;
      if (r_state == S_GET_EXP && w_xfer) r_exp  <= w_cmd_vec;
      // Stimulus reaches the macro only once the whole command is in.
      if (r_state == S_GET_SET && w_xfer) begin
        r_settle <= w_cmd_settle;
        r_mac_in <= r_stim;
      end else if (r_state == S_SETTLE && r_settle != '0) begin
        r_settle <= r_settle - SETTLE_W'(1);
      end
      if (r_state == S_CAPTURE) begin
        r_rsp      <= w_out_byte;
        r_mismatch <= w_mm;
        if (w_mm && r_err != 8'hFF) r_err <= r_err + 8'd1;
      end
    end
  end

  assign mac_in    = r_mac_in;
  assign rsp_data  = r_rsp;
  assign mismatch  = r_mismatch;
  assign err_count = r_err;

endmodule

// File: tb/tb_macro_vector_driver.sv
// Randomized bench for macro_vector_driver against a transaction-level model.
module tb_macro_vector_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] mac_in;
  logic [7:0] mac_out;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       mismatch;
  logic [7:0] err_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_err    = 0;
  int mode     = 0;
  logic [7:0] mask = 8'h00;

  always #5 clk = ~clk;

  // Behavioural macro: loopback, inverter, or xor with a constant mask.
  assign mac_out = (mode == 0) ? mac_in : (mode == 1) ? ~mac_in : (mac_in ^ mask);

  macro_vector_driver #(.SETTLE_W(8), .VEC_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mac_in(mac_in), .mac_out(mac_out),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .mismatch(mismatch), .err_count(err_count), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_resp(input logic [7:0] stim);
    case (mode)
      0:       return stim;
      1:       return ~stim;
      default: return stim ^ mask;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] stim, input logic [7:0] expv,
                         input logic [7:0] settle, input int bp);
    logic [7:0] resp;
    logic       mm;
    int         lat;
    resp = model_resp(stim);
    mm   = (resp != expv);
    if (mm && m_err < 255) m_err++;
    send_byte(stim);
    send_byte(expv);
    send_byte(settle);
    check("mac_in", mac_in, stim);
    check("busy_settle", busy, 1);
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 8'($urandom);
      check("cmd_ready_busy", cmd_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, int'(settle) + 3);
    check("rsp_data", rsp_data, resp);
    check("mismatch", mismatch, mm);
    check("err_count", err_count, m_err);
    repeat (bp) begin
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      @(posedge clk); #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, resp);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_mac_in", mac_in, stim);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("mismatch_hold", mismatch, mm);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mac_in"},    mac_in, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_mismatch"},  mismatch, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    logic [7:0] s, e;
    rst = 1'b1; cmd_data = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b0;
    #2;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    mode = 0;
    run_txn(8'hA5, 8'hA5, 8'h02, 0);
    mode = 1;
    run_txn(8'h3C, 8'h00, 8'h00, 0);
    check("inv_rsp", rsp_data, 8'hC3);
    mode = 2; mask = 8'h5A;
    run_txn(8'($urandom), 8'($urandom), 8'h04, 10);
    mode = 0;
    run_txn(8'h11, 8'h11, 8'h00, 0);
    run_txn(8'h77, 8'h76, 8'hFF, 2);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      mask = 8'($urandom);
      s = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? model_resp(s) : 8'($urandom);
      run_txn(s, e, 8'($urandom_range(0, 20)), $urandom_range(0, 4));
    end

    // Reset pulse in the middle of a long settle.
    mode = 0;
    send_byte(8'h9E);
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals("midrst_hold");
    rst = 1'b0;
    m_err = 0;
    run_txn(8'h42, 8'h42, 8'h03, 1);
    run_txn(8'h42, 8'h24, 8'h01, 0);

    mode = 1;
    for (int i = 0; i < 260; i++) begin
      s = 8'($urandom);
      run_txn(s, s, 8'h00, 0);
    end
    check("sat_err_count", err_count, 8'hFF);
    run_txn(8'h01, 8'h01, 8'h01, 0);
    check("sat_stay", err_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/macro_vector_driver.md
MACRO_VECTOR_DRIVER -- requirements
Module: macro_vector_driver

Interface
REQ-001 SHALL have parameter SETTLE_W, default 8, giving the settle-counter width in bits.
REQ-002 SHALL have parameter VEC_W, default 8, giving the macro stimulus/response vector width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_data, input, 8: host command byte.
REQ-006 SHALL have port cmd_valid, input, 1: cmd_data valid.
REQ-007 SHALL have port cmd_ready, output, 1: block accepts cmd_data this cycle.
REQ-008 SHALL have port mac_in, output, VEC_W: stimulus vector driven into the macro under test.
REQ-009 SHALL have port mac_out, input, VEC_W: response vector from the macro under test.
REQ-010 SHALL have port rsp_data, output, 8: captured macro response.
REQ-011 SHALL have port rsp_valid, output, 1: rsp_data valid.
REQ-012 SHALL have port rsp_ready, input, 1: host accepts rsp_data.
REQ-013 SHALL have port mismatch, output, 1: last capture differed from expected.
REQ-014 SHALL have port err_count, output, 8: saturating count of mismatches since reset.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, GET_EXP, GET_SET, SETTLE, CAPTURE, SEND.
REQ-017 SHALL transfer a command byte only on a cycle with cmd_valid && cmd_ready.
REQ-018 SHALL assert cmd_ready only in IDLE, GET_EXP and GET_SET.
REQ-019 SHALL, in IDLE, on a transfer latch the byte as the stimulus vector and go to GET_EXP.
REQ-020 SHALL, in GET_EXP, on a transfer latch the byte as the expected vector and go to GET_SET.
REQ-021 SHALL, in GET_SET, on a transfer load the settle counter with the byte and go to SETTLE.
REQ-022 SHALL update mac_in with the stimulus on the cycle after the GET_SET transfer and hold it until the next IDLE transfer.
REQ-023 SHALL, in SETTLE, decrement the counter each cycle and go to CAPTURE on the cycle the counter reads 0 (settle 0 = one SETTLE cycle; settle N = N+1 SETTLE cycles).
REQ-024 SHALL, in CAPTURE (one cycle), register mac_out into rsp_data.
REQ-025 SHALL, in CAPTURE, set mismatch = (mac_out != expected) and go to SEND.
REQ-026 SHALL, in CAPTURE, increment err_count when mismatch is set, saturating at 255.
REQ-027 SHALL assert rsp_valid only in SEND and keep rsp_data stable while rsp_valid && !rsp_ready.
REQ-028 SHALL leave SEND for IDLE on the cycle rsp_valid && rsp_ready.
REQ-029 SHALL give a pipeline latency from GET_SET transfer to rsp_valid rising of settle+3 cycles.
REQ-030 SHALL zero-extend or truncate between 8-bit bytes and VEC_W vectors at the LSB.
REQ-031 SHALL ignore cmd_valid outside the cmd_ready states (no buffering, no error).
REQ-032 SHALL hold mismatch until the next CAPTURE.

Reset
REQ-033 SHALL, while rst is high, force state to IDLE regardless of clk, including mid-SETTLE or mid-SEND.
REQ-034 SHALL, while rst is high, hold mac_in, rsp_data, mismatch, err_count, rsp_valid and busy at 0 and cmd_ready at 1.
REQ-035 SHALL, when rst deasserts, begin operation on the next rising clk edge.

Verification
REQ-036 SHALL cover a basic pass: bytes 0xA5, 0xA5, 0x02 with mac_out looped to mac_in -> rsp_valid 5 cycles after the third transfer, rsp_data 0xA5, mismatch 0, err_count 0.
REQ-037 SHALL cover a mismatch: bytes 0x3C, 0x00, 0x00 with mac_out=~mac_in -> rsp_data 0xC3, mismatch 1, err_count 1.
REQ-038 SHALL cover backpressure: rsp_ready held low 10 cycles in SEND -> rsp_valid and rsp_data stable, cmd_ready 0, and cmd_valid ignored throughout.
REQ-039 SHALL cover saturation: 260 mismatching vectors -> err_count saturates at 255 and stays there.
REQ-040 SHALL cover reset mid-operation: rst pulsed during SETTLE with settle 0xFF -> all outputs at reset values, busy 0, and the next 3-byte command completes normally.
REQ-041 SHALL cover settle 0 versus 0xFF: rsp_valid latency measured at 3 and 258 cycles respectively.
